// File: rtl/pong_pkg.sv
// Shared constants and types for the pong frame scheduler.
// Holds coordinate/counter widths, vblank threshold, reset positions and FSM states.
package pong_pkg;

    localparam int CW      = 11;
    localparam int V_DISP  = 480;
    localparam int OVR_W   = 8;
    localparam int FRM_W   = 16;
    localparam int BALL_X0 = 316;
    localparam int BALL_Y0 = 236;
    localparam int PAD_Y0  = 200;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COMMIT
    } frm_state_t;

endpackage

// File: rtl/pong_frame_ctrl.sv
// Frame scheduler: detects vblank start from y, runs one req/ack update per frame,
// and double-buffers object positions so the renderer only sees values committed
// in vblank. Counts frames (wrapping) and aborted requests (saturating).
// Ports: clk, rst_n (sync, active-low), y, pause, upd_req/upd_ack handshake,
// *_in new positions, ball_x/ball_y/pad_l_y/pad_r_y committed positions,
// frame_tick, frame_cnt, overrun_cnt.
module pong_frame_ctrl #(
    parameter int CW      = pong_pkg::CW,
    parameter int V_DISP  = pong_pkg::V_DISP,
    parameter int OVR_W   = pong_pkg::OVR_W,
    parameter int FRM_W   = pong_pkg::FRM_W,
    parameter int BALL_X0 = pong_pkg::BALL_X0,
    parameter int BALL_Y0 = pong_pkg::BALL_Y0,
    parameter int PAD_Y0  = pong_pkg::PAD_Y0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    y,
    input  logic             pause,
    output logic             upd_req,
    input  logic             upd_ack,
    input  logic [CW-1:0]    ball_x_in,
    input  logic [CW-1:0]    ball_y_in,
    input  logic [CW-1:0]    pad_l_in,
    input  logic [CW-1:0]    pad_r_in,
    output logic [CW-1:0]    ball_x,
    output logic [CW-1:0]    ball_y,
    output logic [CW-1:0]    pad_l_y,
    output logic [CW-1:0]    pad_r_y,
    output logic             frame_tick,
    output logic [FRM_W-1:0] frame_cnt,
    output logic [OVR_W-1:0] overrun_cnt
);
    import pong_pkg::*;

    frm_state_t state, state_nxt;

    logic [CW-1:0] y_q;
    logic          vb, vb_q, vb_rise, vb_fall;
    logic          capture, commit, abort;
    logic [CW-1:0] sh_bx, sh_by, sh_pl, sh_pr;

    // Unsigned compare: back-porch lines wrap to large values and so count as vblank.
    assign vb      = (y_q >= CW'(V_DISP));
    assign vb_rise = vb & ~vb_q;
    assign vb_fall = ~vb & vb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q        <= '0;
            vb_q       <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            y_q        <= y;
            vb_q       <= vb;
            frame_tick <= vb_rise;
            if (vb_rise)
                frame_cnt <= frame_cnt + FRM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Ack is checked before vb_fall so a late ack still commits.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (vb_rise && !pause)
                    state_nxt = REQ;
            end
            REQ: begin
                if (upd_ack)
                    state_nxt = COMMIT;
                else if (vb_fall)
                    state_nxt = IDLE;
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_req = (state == REQ);
        capture = (state == REQ) && upd_ack;
        abort   = (state == REQ) && !upd_ack && vb_fall;
        commit  = (state == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_bx <= '0;
            sh_by <= '0;
            sh_pl <= '0;
            sh_pr <= '0;
        end else if (capture) begin
            sh_bx <= ball_x_in;
            sh_by <= ball_y_in;
            sh_pl <= pad_l_in;
            sh_pr <= pad_r_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ball_x  <= CW'(BALL_X0);
            ball_y  <= CW'(BALL_Y0);
            pad_l_y <= CW'(PAD_Y0);
            pad_r_y <= CW'(PAD_Y0);
        end else if (commit) begin
            ball_x  <= sh_bx;
            ball_y  <= sh_by;
            pad_l_y <= sh_pl;
            pad_r_y <= sh_pr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            overrun_cnt <= '0;
        else if (abort && (overrun_cnt != '1))
            overrun_cnt <= overrun_cnt + OVR_W'(1);
    end

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Self-checking bench for pong_frame_ctrl: vector table, directed corner
// sequences and a randomized run compared against a frame-level reference model.
module tb_pong_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] y;
    logic        pause;
    logic        upd_req;
    logic        upd_ack;
    logic [10:0] bx_in, by_in, pl_in, pr_in;
    logic [10:0] ball_x, ball_y, pad_l_y, pad_r_y;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [7:0]  overrun_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_frame_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .y           (y),
        .pause       (pause),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .ball_x_in   (bx_in),
        .ball_y_in   (by_in),
        .pad_l_in    (pl_in),
        .pad_r_in    (pr_in),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .pad_l_y     (pad_l_y),
        .pad_r_y     (pad_r_y),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt)
    );

    // Reference model: tracks "a request is outstanding" and "an update is
    // waiting to be shown", driven by vblank edges seen one line-sample late.
    int  m_yq;
    bit  m_vbq;
    bit  m_pending;
    bit  m_show;
    int  m_new[4];
    int  m_pos[4];
    int  m_frames;
    int  m_ovr;
    bit  m_tick;
    bit  mcmp = 1'b0;
    bit  req_seen;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_step(input bit rn, input int yv, input bit pz,
                              input bit ack, input int a, input int b,
                              input int c, input int d);
        bit vbn, rise, fall;
        if (!rn) begin
            m_yq = 0; m_vbq = 0; m_pending = 0; m_show = 0;
            m_frames = 0; m_ovr = 0; m_tick = 0;
            m_pos = '{316, 236, 200, 200};
        end else begin
            vbn  = (m_yq >= 480);
            rise = vbn && !m_vbq;
            fall = !vbn && m_vbq;
            m_tick = rise;
            if (rise) m_frames = (m_frames + 1) % 65536;
            if (m_show) begin
                m_pos  = m_new;
                m_show = 0;
            end else if (m_pending) begin
                if (ack) begin
                    m_new = '{a, b, c, d};
                    m_show = 1;
                    m_pending = 0;
                end else if (fall) begin
                    m_pending = 0;
                    if (m_ovr < 255) m_ovr++;
                end
            end else if (rise && !pz) begin
                m_pending = 1;
            end
            m_yq  = yv;
            m_vbq = vbn;
        end
    endtask

    task automatic cyc(input bit rn, input logic [10:0] yv, input bit pz,
                       input bit ack, input logic [10:0] a,
                       input logic [10:0] b, input logic [10:0] c,
                       input logic [10:0] d);
        @(negedge clk);
        rst_n = rn; y = yv; pause = pz; upd_ack = ack;
        bx_in = a; by_in = b; pl_in = c; pr_in = d;
        @(posedge clk);
        model_step(rn, int'(yv), pz, ack, int'(a), int'(b), int'(c), int'(d));
        #1;
        req_seen |= upd_req;
        if (mcmp) begin
            chk("rnd upd_req",    upd_req,     m_pending);
            chk("rnd frame_tick", frame_tick,  m_tick);
            chk("rnd frame_cnt",  frame_cnt,   m_frames);
            chk("rnd overrun",    overrun_cnt, m_ovr);
            chk("rnd ball_x",     ball_x,      m_pos[0]);
            chk("rnd ball_y",     ball_y,      m_pos[1]);
            chk("rnd pad_l",      pad_l_y,     m_pos[2]);
            chk("rnd pad_r",      pad_r_y,     m_pos[3]);
        end
    endtask

    // One frame: 3 active lines, 4 vblank samples (incl. wrapped), 3 active.
    task automatic vframe(input int ack_idx, input bit pz,
                          input logic [10:0] a, input logic [10:0] b,
                          input logic [10:0] c, input logic [10:0] d);
        logic [10:0] ys [10];
        ys = '{11'd10, 11'd10, 11'd10, 11'd480, 11'd524, 11'd2047,
               11'd1600, 11'd5, 11'd6, 11'd7};
        for (int i = 0; i < 10; i++) begin
            if (i == ack_idx)
                cyc(1, ys[i], pz, 1, a, b, c, d);
            else
                cyc(1, ys[i], pz, 0, 11'd999, 11'd999, 11'd999, 11'd999);
        end
    endtask

    typedef struct {
        logic [10:0] yv;
        bit          ack;
        logic [10:0] a, b, c, d;
        bit          e_req, e_tick;
        int          e_cnt;
        int          e_pos[4];
    } vec_t;

    vec_t vt[8];

    initial begin
        int ycnt;
        logic [10:0] yd;

        vt[0] = '{11'd479, 0, 11'd999, 11'd999, 11'd999, 11'd999, 0, 0, 0,
                  '{316, 236, 200, 200}};
        vt[1] = '{11'd480, 0, 11'd999, 11'd999, 11'd999, 11'd999, 0, 0, 0,
                  '{316, 236, 200, 200}};
        vt[2] = '{11'd481, 0, 11'd999, 11'd999, 11'd999, 11'd999, 1, 1, 1,
                  '{316, 236, 200, 200}};
        vt[3] = '{11'd482, 0, 11'd999, 11'd999, 11'd999, 11'd999, 1, 0, 1,
                  '{316, 236, 200, 200}};
        vt[4] = '{11'd483, 0, 11'd999, 11'd999, 11'd999, 11'd999, 1, 0, 1,
                  '{316, 236, 200, 200}};
        vt[5] = '{11'd484, 1, 11'd100, 11'd50, 11'd60, 11'd70, 0, 0, 1,
                  '{316, 236, 200, 200}};
        vt[6] = '{11'd485, 0, 11'd999, 11'd999, 11'd999, 11'd999, 0, 0, 1,
                  '{100, 50, 60, 70}};
        vt[7] = '{11'd486, 1, 11'd999, 11'd999, 11'd999, 11'd999, 0, 0, 1,
                  '{100, 50, 60, 70}};

        rst_n = 0; y = '0; pause = 0; upd_ack = 0;
        bx_in = '0; by_in = '0; pl_in = '0; pr_in = '0;

        for (int i = 0; i < 3; i++)
            cyc(0, 11'd0, 0, 0, 11'd0, 11'd0, 11'd0, 11'd0);
        chk("reset ball_x",  ball_x,      316);
        chk("reset ball_y",  ball_y,      236);
        chk("reset pad_l",   pad_l_y,     200);
        chk("reset pad_r",   pad_r_y,     200);
        chk("reset frames",  frame_cnt,   0);
        chk("reset overrun", overrun_cnt, 0);
        chk("reset upd_req", upd_req,     0);
        chk("reset tick",    frame_tick,  0);

        for (int i = 0; i < 8; i++) begin
            cyc(1, vt[i].yv, 0, vt[i].ack, vt[i].a, vt[i].b, vt[i].c,
                vt[i].d);
            chk($sformatf("vec%0d upd_req", i), upd_req,    vt[i].e_req);
            chk($sformatf("vec%0d tick", i),    frame_tick, vt[i].e_tick);
            chk($sformatf("vec%0d frames", i),  frame_cnt,  vt[i].e_cnt);
            chk($sformatf("vec%0d overrun", i), overrun_cnt, 0);
            chk($sformatf("vec%0d ball_x", i),  ball_x,  vt[i].e_pos[0]);
            chk($sformatf("vec%0d ball_y", i),  ball_y,  vt[i].e_pos[1]);
            chk($sformatf("vec%0d pad_l", i),   pad_l_y, vt[i].e_pos[2]);
            chk($sformatf("vec%0d pad_r", i),   pad_r_y, vt[i].e_pos[3]);
        end

        vframe(-1, 0, 11'd1, 11'd1, 11'd1, 11'd1);
        chk("ovr1 overrun", overrun_cnt, 1);
        chk("ovr1 upd_req", upd_req,     0);
        chk("ovr1 ball_x",  ball_x,      100);
        chk("ovr1 pad_r",   pad_r_y,     70);
        chk("ovr1 frames",  frame_cnt,   2);
        for (int i = 0; i < 299; i++)
            vframe(-1, 0, 11'd1, 11'd1, 11'd1, 11'd1);
        chk("ovr sat overrun", overrun_cnt, 255);
        chk("ovr sat frames",  frame_cnt,   301);
        chk("ovr sat ball_y",  ball_y,      50);

        vframe(8, 0, 11'd11, 11'd22, 11'd33, 11'd44);
        chk("ackfall overrun", overrun_cnt, 255);
        chk("ackfall ball_x",  ball_x,      11);
        chk("ackfall ball_y",  ball_y,      22);
        chk("ackfall pad_l",   pad_l_y,     33);
        chk("ackfall pad_r",   pad_r_y,     44);
        chk("ackfall frames",  frame_cnt,   302);

        req_seen = 0;
        for (int i = 0; i < 4; i++)
            vframe(6, 1, 11'd500, 11'd500, 11'd500, 11'd500);
        chk("pause req_seen", req_seen,  0);
        chk("pause frames",   frame_cnt, 306);
        chk("pause ball_x",   ball_x,    11);
        chk("pause pad_r",    pad_r_y,   44);

        for (int i = 0; i < 3; i++)
            cyc(1, 11'd10, 0, 0, 11'd999, 11'd999, 11'd999, 11'd999);
        for (int i = 0; i < 3; i++)
            cyc(1, 11'd480, 0, 0, 11'd999, 11'd999, 11'd999, 11'd999);
        chk("rstreq upd_req before", upd_req, 1);
        cyc(0, 11'd480, 0, 1, 11'd7, 11'd7, 11'd7, 11'd7);
        chk("rstreq upd_req", upd_req,     0);
        chk("rstreq ball_x",  ball_x,      316);
        chk("rstreq pad_l",   pad_l_y,     200);
        chk("rstreq frames",  frame_cnt,   0);
        chk("rstreq overrun", overrun_cnt, 0);
        for (int i = 0; i < 4; i++)
            cyc(1, 11'd10, 0, 0, 11'd999, 11'd999, 11'd999, 11'd999);
        chk("rstreq after overrun", overrun_cnt, 0);
        chk("rstreq after ball_x",  ball_x,      316);
        chk("rstreq after upd_req", upd_req,     0);

        cyc(0, 11'd0, 0, 0, 11'd0, 11'd0, 11'd0, 11'd0);
        mcmp = 1;
        ycnt = 0;
        for (int i = 0; i < 4000; i++) begin
            ycnt = (ycnt + int'($urandom_range(1, 60))) % 525;
            yd = (ycnt >= 515) ? 11'(ycnt - 525) : 11'(ycnt);
            cyc(($urandom_range(0, 299) != 0), yd,
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
        end
        mcmp = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
